// File: rtl/bus_grant_sequencer.sv
// Purpose: queues 4-bit grant tags from the bus arbiter and turns each tag into one bus ownership window.
// Latency: a tag pushed into an empty FIFO while idle drives its owner bit from the next rising edge.
// Backpressure: none upstream; a push into a full FIFO is dropped and flagged by a one-cycle overflow pulse.
module bus_grant_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [3:0]               fifo_data_in,
    input  logic [3:0]               xfer_done,
    output logic [3:0]               owner_proc,
    output logic [3:0]               owner_snoop,
    output logic [1:0]               owner_id,
    output logic                     bus_busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     bad_tag,
    output logic                     timeout
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(TIMEOUT);

    localparam logic [1:0] TYPE_PROC  = 2'b01;
    localparam logic [1:0] TYPE_SNOOP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    // Tag storage and pointers
    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;

    // Control state
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;

    // Registered outputs
    logic [3:0]      r_owner_proc;
    logic [3:0]      r_owner_snoop;
    logic [1:0]      r_owner_id;
    logic            r_bus_busy;
    logic            r_overflow;
    logic            r_bad_tag;
    logic            r_timeout;

    // Combinational decode
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_grant;
    logic            w_bad;
    logic            w_end;
    logic            w_tmo;
    logic [3:0]      w_head;
    logic [1:0]      w_head_type;
    logic [1:0]      w_head_id;
    logic            w_head_ok;
    logic            w_done;
    logic            w_tmo_hit;

    assign w_full      = (r_count == CNTW'(DEPTH));
    assign w_empty     = (r_count == '0);
    // Full is judged before any same-edge pop, so a push into a full FIFO is
    // always dropped even if the FSM pops on that edge.
    assign w_push      = wr_en & ~w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_type = w_head[3:2];
    assign w_head_id   = w_head[1:0];
    assign w_head_ok   = (w_head_type == TYPE_PROC) || (w_head_type == TYPE_SNOOP);
    // Only the current owner's completion strobe counts.
    assign w_done      = xfer_done[r_owner_id];
    assign w_tmo_hit   = (r_cnt == CW'(TIMEOUT - 1));

    // Tag memory write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_data_in;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_grant     = 1'b0;
        w_bad       = 1'b0;
        w_end       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_ok) begin
                        w_grant     = 1'b1;
                        w_state_nxt = ST_GRANT;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                // Completion on the last allowed cycle beats the timeout.
                if (w_done) begin
                    w_end       = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else if (w_tmo_hit) begin
                    w_end       = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // GRANT cycle counter: zero on entry, counts each cycle spent in GRANT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_grant) begin
            r_cnt <= '0;
        end else if (r_state == ST_GRANT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Ownership registers: loaded on the popping edge, cleared when GRANT ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_proc  <= '0;
            r_owner_snoop <= '0;
            r_owner_id    <= '0;
            r_bus_busy    <= 1'b0;
        end else if (w_grant) begin
            r_owner_proc  <= (w_head_type == TYPE_PROC)  ? (4'b0001 << w_head_id) : 4'b0000;
            r_owner_snoop <= (w_head_type == TYPE_SNOOP) ? (4'b0001 << w_head_id) : 4'b0000;
            r_owner_id    <= w_head_id;
            r_bus_busy    <= 1'b1;
        end else if (w_end) begin
            r_owner_proc  <= '0;
            r_owner_snoop <= '0;
            r_owner_id    <= '0;
            r_bus_busy    <= 1'b0;
        end
    end

    // One-cycle event pulses, visible in the cycle after the causing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_bad_tag  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_overflow <= wr_en & w_full;
            r_bad_tag  <= w_bad;
            r_timeout  <= w_tmo;
        end
    end

    assign owner_proc  = r_owner_proc;
    assign owner_snoop = r_owner_snoop;
    assign owner_id    = r_owner_id;
    assign bus_busy    = r_bus_busy;
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign bad_tag     = r_bad_tag;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// Bench for bus_grant_sequencer: directed tag sequences with hand-computed expected grants.
// Expected grants and event pulses are queued by the stimulus; a negedge monitor pops and compares.
// Timing-specific properties (latency, release, async reset) are checked inline by the stimulus.
module tb_bus_grant_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    localparam logic [1:0] K_GRANT = 2'd0;
    localparam logic [1:0] K_BAD   = 2'd1;
    localparam logic [1:0] K_OVF   = 2'd2;
    localparam logic [1:0] K_TMO   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] proc;
        logic [3:0] snoop;
        logic [1:0] id;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] fifo_data_in;
    logic [3:0] xfer_done;
    logic [3:0] owner_proc;
    logic [3:0] owner_snoop;
    logic [1:0] owner_id;
    logic       bus_busy;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       bad_tag;
    logic       timeout;

    int   n_checks = 0;
    int   n_err    = 0;
    logic prev_busy = 1'b0;

    ev_t exp_grant_q[$];
    ev_t exp_flag_q[$];

    // Fill sequence for the overflow test and the hand-decoded grants it must produce.
    logic [3:0] fill_tag [8] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111,
                                 4'b1000, 4'b1001, 4'b1010, 4'b1011};
    ev_t fill_exp [8] = '{'{K_GRANT, 4'b0001, 4'b0000, 2'd0},
                          '{K_GRANT, 4'b0010, 4'b0000, 2'd1},
                          '{K_GRANT, 4'b0100, 4'b0000, 2'd2},
                          '{K_GRANT, 4'b1000, 4'b0000, 2'd3},
                          '{K_GRANT, 4'b0000, 4'b0001, 2'd0},
                          '{K_GRANT, 4'b0000, 4'b0010, 2'd1},
                          '{K_GRANT, 4'b0000, 4'b0100, 2'd2},
                          '{K_GRANT, 4'b0000, 4'b1000, 2'd3}};
    logic [3:0] fill_rel [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    bus_grant_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .fifo_data_in (fifo_data_in),
        .xfer_done    (xfer_done),
        .owner_proc   (owner_proc),
        .owner_snoop  (owner_snoop),
        .owner_id     (owner_id),
        .bus_busy     (bus_busy),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .bad_tag      (bad_tag),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h required=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // One push per call; consecutive calls push on consecutive edges.
    task automatic push(input logic [3:0] tag);
        wr_en        = 1'b1;
        fifo_data_in = tag;
        step(1);
        wr_en        = 1'b0;
    endtask

    task automatic sb_grant(input ev_t got);
        ev_t e;
        n_checks++;
        if (exp_grant_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_grant: unexpected grant proc=%b snoop=%b id=%0d, none required", got.proc, got.snoop, got.id);
        end else begin
            e = exp_grant_q.pop_front();
            if (got !== e) begin
                n_err++;
                $display("FAIL sb_grant: got proc=%b snoop=%b id=%0d required proc=%b snoop=%b id=%0d",
                         got.proc, got.snoop, got.id, e.proc, e.snoop, e.id);
            end
        end
    endtask

    task automatic sb_flag(input logic [1:0] kind);
        ev_t e;
        n_checks++;
        if (exp_flag_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_flag: unexpected pulse kind=%0d, none required at t=%0t", kind, $time);
        end else begin
            e = exp_flag_q.pop_front();
            if (e.kind !== kind) begin
                n_err++;
                $display("FAIL sb_flag: got pulse kind=%0d required kind=%0d at t=%0t", kind, e.kind, $time);
            end
        end
    endtask

    // Monitor: every new ownership window and every event pulse is an output to score.
    initial begin
        ev_t g;
        forever begin
            @(negedge clk);
            if (bus_busy && !prev_busy) begin
                g.kind  = K_GRANT;
                g.proc  = owner_proc;
                g.snoop = owner_snoop;
                g.id    = owner_id;
                sb_grant(g);
            end
            if (bad_tag)  sb_flag(K_BAD);
            if (overflow) sb_flag(K_OVF);
            if (timeout)  sb_flag(K_TMO);
            prev_busy = bus_busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst          = 1'b1;
        wr_en        = 1'b0;
        fifo_data_in = 4'b0000;
        xfer_done    = 4'b0000;

        // Reset state
        #12;
        chk("rst_owner", 32'({owner_proc, owner_snoop, owner_id, bus_busy}), 0);
        chk("rst_fifo", 32'({full, empty, count}), 32'(6'b010000));
        chk("rst_pulses", 32'({overflow, bad_tag, timeout}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);

        // Single processor grant: 0110 -> core 2
        exp_grant_q.push_back('{K_GRANT, 4'b0100, 4'b0000, 2'd2});
        push(4'b0110);
        chk("t1_count_after_push", 32'(count), 1);
        chk("t1_no_owner_at_push", 32'(bus_busy), 0);
        step(1);
        chk("t1_owner_proc", 32'(owner_proc), 32'(4'b0100));
        chk("t1_owner_id", 32'(owner_id), 2);
        chk("t1_busy", 32'(bus_busy), 1);
        chk("t1_count_popped", 32'(count), 0);
        step(2);
        chk("t1_hold", 32'(bus_busy), 1);
        xfer_done = 4'b0100;
        step(1);
        xfer_done = 4'b0000;
        chk("t1_release", 32'({owner_proc, owner_snoop, bus_busy}), 0);
        step(1);
        chk("t1_release_2nd", 32'(bus_busy), 0);

        // Snoop grant: 1011 -> core 3, foreign xfer_done ignored
        exp_grant_q.push_back('{K_GRANT, 4'b0000, 4'b1000, 2'd3});
        push(4'b1011);
        step(1);
        chk("t2_owner_snoop", 32'(owner_snoop), 32'(4'b1000));
        chk("t2_owner_proc_zero", 32'(owner_proc), 0);
        xfer_done = 4'b0001;
        step(3);
        chk("t2_ignore_other_core", 32'(bus_busy), 1);
        xfer_done = 4'b1000;
        step(1);
        xfer_done = 4'b0000;
        chk("t2_release", 32'({owner_snoop, bus_busy}), 0);
        step(1);

        // Full / overflow while core 0 holds the bus, then drain in order
        exp_grant_q.push_back('{K_GRANT, 4'b0001, 4'b0000, 2'd0});
        push(4'b0100);
        step(1);
        chk("t3_holder_busy", 32'(bus_busy), 1);
        for (int i = 0; i < 8; i++) begin
            exp_grant_q.push_back(fill_exp[i]);
            push(fill_tag[i]);
        end
        chk("t3_count_full", 32'(count), 8);
        chk("t3_full", 32'(full), 1);
        exp_flag_q.push_back('{K_OVF, 4'b0000, 4'b0000, 2'd0});
        push(4'b0111);
        chk("t3_count_after_drop", 32'(count), 8);
        chk("t3_overflow", 32'(overflow), 1);
        step(1);
        chk("t3_overflow_one_cycle", 32'(overflow), 0);
        xfer_done = 4'b0001;
        step(1);
        xfer_done = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (!bus_busy && k < 10) begin
                step(1);
                k++;
            end
            chk("t3_drain_grant", 32'(bus_busy), 1);
            xfer_done = fill_rel[i];
            step(1);
            xfer_done = 4'b0000;
            chk("t3_drain_release", 32'(bus_busy), 0);
        end
        step(2);
        chk("t3_drained_empty", 32'({empty, count}), 32'(5'b10000));

        // Bad tag followed by a valid one; the second push coincides with the pop
        exp_flag_q.push_back('{K_BAD, 4'b0000, 4'b0000, 2'd0});
        exp_grant_q.push_back('{K_GRANT, 4'b0001, 4'b0000, 2'd0});
        push(4'b0001);
        push(4'b0100);
        chk("t4_count_push_pop", 32'(count), 1);
        chk("t4_bad_tag", 32'(bad_tag), 1);
        chk("t4_no_owner", 32'(bus_busy), 0);
        step(1);
        chk("t4_owner_proc", 32'(owner_proc), 32'(4'b0001));
        chk("t4_bad_tag_one_cycle", 32'(bad_tag), 0);
        xfer_done = 4'b0001;
        step(1);
        xfer_done = 4'b0000;
        step(1);

        // Timeout: 16 GRANT cycles then forced release
        exp_grant_q.push_back('{K_GRANT, 4'b1000, 4'b0000, 2'd3});
        exp_flag_q.push_back('{K_TMO, 4'b0000, 4'b0000, 2'd0});
        push(4'b0111);
        step(1);
        chk("t5_grant", 32'(bus_busy), 1);
        step(15);
        chk("t5_busy_cycle16", 32'(bus_busy), 1);
        chk("t5_no_early_timeout", 32'(timeout), 0);
        step(1);
        chk("t5_forced_release", 32'(bus_busy), 0);
        chk("t5_timeout_pulse", 32'(timeout), 1);
        step(1);
        chk("t5_timeout_one_cycle", 32'(timeout), 0);

        // xfer_done on cycle 16 wins over the timeout
        exp_grant_q.push_back('{K_GRANT, 4'b1000, 4'b0000, 2'd3});
        push(4'b0111);
        step(1);
        step(15);
        xfer_done = 4'b1000;
        step(1);
        xfer_done = 4'b0000;
        chk("t5b_release", 32'(bus_busy), 0);
        chk("t5b_no_timeout", 32'(timeout), 0);
        step(1);

        // Asynchronous reset mid-GRANT with three queued tags
        exp_grant_q.push_back('{K_GRANT, 4'b0100, 4'b0000, 2'd2});
        push(4'b0110);
        step(1);
        chk("t6_grant", 32'(bus_busy), 1);
        push(4'b1000);
        push(4'b1001);
        push(4'b1010);
        chk("t6_count3", 32'(count), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_owner", 32'({owner_proc, owner_snoop, bus_busy}), 0);
        chk("t6_async_fifo", 32'({empty, count}), 32'(5'b10000));
        step(2);
        rst = 1'b0;
        step(1);
        chk("t6_idle_after_reset", 32'({bus_busy, empty, count}), 32'(6'b010000));
        exp_grant_q.push_back('{K_GRANT, 4'b0000, 4'b0010, 2'd1});
        push(4'b1001);
        step(1);
        chk("t6_post_reset_grant", 32'(owner_snoop), 32'(4'b0010));
        xfer_done = 4'b0010;
        step(1);
        xfer_done = 4'b0000;
        step(3);

        chk("sb_grants_all_seen", 32'(exp_grant_q.size()), 0);
        chk("sb_pulses_all_seen", 32'(exp_flag_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
